// File: rtl/piano_pkg.sv
// Shared constants and types for the piano buzzer tone path.
package piano_pkg;

  localparam int unsigned KEY_W = 4;
  localparam int unsigned OCT_W = 2;

  // Key codes from the song player.
  localparam logic [KEY_W-1:0] KEY_REST     = 4'd0;
  localparam logic [KEY_W-1:0] KEY_C4       = 4'd1;
  localparam logic [KEY_W-1:0] KEY_D4       = 4'd2;
  localparam logic [KEY_W-1:0] KEY_E4       = 4'd3;
  localparam logic [KEY_W-1:0] KEY_F4       = 4'd4;
  localparam logic [KEY_W-1:0] KEY_G4       = 4'd5;
  localparam logic [KEY_W-1:0] KEY_A4       = 4'd6;
  localparam logic [KEY_W-1:0] KEY_B4       = 4'd7;
  localparam logic [KEY_W-1:0] KEY_C5       = 4'd8;
  localparam logic [KEY_W-1:0] KEY_D5       = 4'd9;
  localparam logic [KEY_W-1:0] KEY_E5       = 4'd10;
  localparam logic [KEY_W-1:0] KEY_F5       = 4'd11;
  localparam logic [KEY_W-1:0] KEY_G5       = 4'd12;
  localparam logic [KEY_W-1:0] KEY_A5       = 4'd13;
  localparam logic [KEY_W-1:0] KEY_B5       = 4'd14;
  localparam logic [KEY_W-1:0] KEY_REST_ALT = 4'd15;

  // Fourth-octave note frequencies in Hz.
  localparam int unsigned F_C4 = 262;
  localparam int unsigned F_D4 = 294;
  localparam int unsigned F_E4 = 330;
  localparam int unsigned F_F4 = 349;
  localparam int unsigned F_G4 = 392;
  localparam int unsigned F_A4 = 440;
  localparam int unsigned F_B4 = 494;

  // Octave select encodings.
  localparam logic [OCT_W-1:0] OCT_NORM     = 2'd0;
  localparam logic [OCT_W-1:0] OCT_UP       = 2'd1;
  localparam logic [OCT_W-1:0] OCT_DOWN     = 2'd2;
  localparam logic [OCT_W-1:0] OCT_NORM_ALT = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PLAY    = 2'd1,
    ST_RELEASE = 2'd2
  } tone_state_e;

  // Half-period in clocks, rounded to nearest: round(clk_hz / (2*f_hz)).
  function automatic int unsigned half_period_div(input int unsigned clk_hz,
                                                  input int unsigned f_hz);
    return (clk_hz + f_hz) / (2 * f_hz);
  endfunction

endpackage

// File: rtl/note_div_lut.sv
// Combinational (key, octave) -> half-period divider lookup.
module note_div_lut
  import piano_pkg::*;
#(
  parameter int unsigned CLK_HZ = 100_000_000,
  parameter int unsigned DIV_W  = 19
) (
  input  logic [KEY_W-1:0] key,
  input  logic [OCT_W-1:0] octave,
  output logic [DIV_W-1:0] div_c
);

  localparam int unsigned DIV_C4 = half_period_div(CLK_HZ, F_C4);
  localparam int unsigned DIV_D4 = half_period_div(CLK_HZ, F_D4);
  localparam int unsigned DIV_E4 = half_period_div(CLK_HZ, F_E4);
  localparam int unsigned DIV_F4 = half_period_div(CLK_HZ, F_F4);
  localparam int unsigned DIV_G4 = half_period_div(CLK_HZ, F_G4);
  localparam int unsigned DIV_A4 = half_period_div(CLK_HZ, F_A4);
  localparam int unsigned DIV_B4 = half_period_div(CLK_HZ, F_B4);

  logic [31:0] base;
  logic [31:0] scaled;

  // Pick the base divider, halve it for the fifth octave, then apply octave shift.
  always_comb begin
    base   = '0;
    scaled = '0;
    case (key)
      KEY_C4, KEY_C5: base = DIV_C4;
      KEY_D4, KEY_D5: base = DIV_D4;
      KEY_E4, KEY_E5: base = DIV_E4;
      KEY_F4, KEY_F5: base = DIV_F4;
      KEY_G4, KEY_G5: base = DIV_G4;
      KEY_A4, KEY_A5: base = DIV_A4;
      KEY_B4, KEY_B5: base = DIV_B4;
      default:        base = '0;
    endcase
    if (key >= KEY_C5 && key <= KEY_B5) begin
      base = base >> 1;
    end
    case (octave)
      OCT_UP:   scaled = base >> 1;
      OCT_DOWN: scaled = base << 1;
      default:  scaled = base;
    endcase
    div_c = DIV_W'(scaled);
  end

endmodule

// File: rtl/buzzer_tone_gen.sv
// Square-wave buzzer driver with half-period-aligned pitch changes and release.
module buzzer_tone_gen
  import piano_pkg::*;
#(
  parameter int unsigned CLK_HZ = 100_000_000,
  parameter int unsigned DIV_W  = 19
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [KEY_W-1:0] key,
  input  logic             key_on,
  input  logic [OCT_W-1:0] octave,
  output logic             speaker,
  output logic             active,
  output logic [KEY_W-1:0] cur_key
);

  tone_state_e      state_q, state_d;
  logic [KEY_W-1:0] key_q, key_d;
  logic             on_q, on_d;
  logic [OCT_W-1:0] oct_q, oct_d;
  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [DIV_W-1:0] div_cur_q, div_cur_d;
  logic [DIV_W-1:0] div_next_q, div_next_d;
  logic [KEY_W-1:0] key_next_q, key_next_d;
  logic [KEY_W-1:0] cur_key_q, cur_key_d;
  logic             spk_q, spk_d;
  logic             active_q, active_d;

  logic [DIV_W-1:0] lut_div_c;
  logic             want_c;
  logic             boundary_c;

  note_div_lut #(
    .CLK_HZ (CLK_HZ),
    .DIV_W  (DIV_W)
  ) u_lut (
    .key    (key_q),
    .octave (oct_q),
    .div_c  (lut_div_c)
  );

  assign want_c     = on_q && (key_q != KEY_REST) && (key_q != KEY_REST_ALT);
  assign boundary_c = (cnt_q == div_cur_q - DIV_W'(1));

  // Next-state: start on IDLE, swap pitch at boundaries, park low on release.
  always_comb begin
    key_d      = key;
    on_d       = key_on;
    oct_d      = octave;
    state_d    = state_q;
    cnt_d      = cnt_q;
    div_cur_d  = div_cur_q;
    div_next_d = div_next_q;
    key_next_d = key_next_q;
    cur_key_d  = cur_key_q;
    spk_d      = spk_q;

    // Pending pitch follows the inputs while sounding is wanted, frozen otherwise.
    if (want_c) begin
      div_next_d = lut_div_c;
      key_next_d = key_q;
    end

    unique case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        spk_d = 1'b0;
        if (want_c) begin
          div_cur_d = lut_div_c;
          cur_key_d = key_q;
          spk_d     = 1'b1;
          state_d   = ST_PLAY;
        end
      end
      ST_PLAY, ST_RELEASE: begin
        cnt_d = cnt_q + DIV_W'(1);
        if (state_q == ST_RELEASE && !want_c) begin
          if (boundary_c) begin
            cnt_d     = '0;
            spk_d     = 1'b0;
            cur_key_d = KEY_REST;
            state_d   = ST_IDLE;
          end
        end else begin
          if (boundary_c) begin
            cnt_d     = '0;
            spk_d     = ~spk_q;
            div_cur_d = div_next_q;
            cur_key_d = key_next_q;
          end
          state_d = want_c ? ST_PLAY : ST_RELEASE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    active_d = (state_d != ST_IDLE);
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      key_q      <= '0;
      on_q       <= 1'b0;
      oct_q      <= '0;
      cnt_q      <= '0;
      div_cur_q  <= '0;
      div_next_q <= '0;
      key_next_q <= '0;
      cur_key_q  <= '0;
      spk_q      <= 1'b0;
      active_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      key_q      <= key_d;
      on_q       <= on_d;
      oct_q      <= oct_d;
      cnt_q      <= cnt_d;
      div_cur_q  <= div_cur_d;
      div_next_q <= div_next_d;
      key_next_q <= key_next_d;
      cur_key_q  <= cur_key_d;
      spk_q      <= spk_d;
      active_q   <= active_d;
    end
  end

  assign speaker = spk_q;
  assign active  = active_q;
  assign cur_key = cur_key_q;

endmodule

// File: tb/tb_buzzer_tone_gen.sv
// Self-checking bench for buzzer_tone_gen at a scaled-down clock rate.
module tb_buzzer_tone_gen;

  localparam int unsigned P_CLK_HZ = 100_000;
  localparam int unsigned P_DIV_W  = 19;
  localparam int          MAXW     = 2000;
  localparam int          FREQ [7] = '{262, 294, 330, 349, 392, 440, 494};

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] key;
  logic       key_on;
  logic [1:0] octave;
  logic       speaker;
  logic       active;
  logic [3:0] cur_key;

  int n_checks = 0;
  int n_pass   = 0;

  buzzer_tone_gen #(
    .CLK_HZ (P_CLK_HZ),
    .DIV_W  (P_DIV_W)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .key     (key),
    .key_on  (key_on),
    .octave  (octave),
    .speaker (speaker),
    .active  (active),
    .cur_key (cur_key)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  // Expected half-period from note frequency: nearest-integer divide, octave shifts.
  function automatic int exp_div(input int k, input int o);
    int b;
    if (k == 0 || k == 15) return 0;
    b = int'(real'(P_CLK_HZ) / (2.0 * real'(FREQ[(k - 1) % 7])));
    if (k >= 8) b = b / 2;
    if (o == 1) b = b / 2;
    else if (o == 2) b = b * 2;
    return b;
  endfunction

  // Cycles until speaker reaches lvl (MAXW on timeout).
  task automatic wait_spk(input logic lvl, output int n);
    n = 0;
    while (speaker !== lvl && n < MAXW) begin
      @(negedge clk);
      n++;
    end
  endtask

  // Cycles until active drops; counts cycles where speaker left hold_lvl early.
  task automatic wait_idle(input logic hold_lvl, output int n, output int glitch);
    n = 0;
    glitch = 0;
    while (active === 1'b1 && n < MAXW) begin
      @(negedge clk);
      n++;
      if (active === 1'b1 && speaker !== hold_lvl) glitch++;
    end
  endtask

  task automatic start_note(input int k, input int o);
    key    = 4'(k);
    octave = 2'(o);
    key_on = 1'b1;
  endtask

  initial begin
    int n, g, d1, d2, k1, k2, o1, o2, off, dropped;

    rst = 1'b1; key = '0; key_on = 1'b0; octave = '0;
    repeat (3) @(negedge clk);
    check_eq("reset_speaker", int'(speaker), 0);
    check_eq("reset_active",  int'(active),  0);
    check_eq("reset_cur_key", int'(cur_key), 0);
    rst = 1'b0;
    @(negedge clk);

    // A4 from idle: two-cycle start, symmetric half-periods.
    start_note(6, 0);
    wait_spk(1'b1, n); check_eq("a4_rise_latency", n, 2);
    check_eq("a4_active",  int'(active),  1);
    check_eq("a4_cur_key", int'(cur_key), 6);
    wait_spk(1'b0, n); check_eq("a4_high", n, exp_div(6, 0));
    wait_spk(1'b1, n); check_eq("a4_low",  n, exp_div(6, 0));

    // Mid-half-period change to B4 completes the A4 half first.
    repeat (40) @(negedge clk);
    key = 4'd7;
    wait_spk(1'b0, n); check_eq("a4_to_b4_finish", n, exp_div(6, 0) - 40);
    check_eq("b4_cur_key", int'(cur_key), 7);
    wait_spk(1'b1, n); check_eq("b4_low", n, exp_div(7, 0));
    key_on = 1'b0;
    wait_idle(1'b1, n, g); check_eq("b4_release_len", n, exp_div(7, 0));
    check_eq("b4_release_glitch", g, 0);

    // C4 under each octave setting.
    for (int o = 1; o <= 3; o++) begin
      start_note(1, (o == 1) ? 2 : (o == 2) ? 1 : 3);
      wait_spk(1'b1, n); check_eq("oct_rise_latency", n, 2);
      wait_spk(1'b0, n); check_eq("oct_high", n, exp_div(1, int'(octave)));
      key_on = 1'b0;
      wait_idle(1'b0, n, g); check_eq("oct_release_len", n, exp_div(1, int'(octave)));
    end
    octave = 2'd0;

    // Release mid high phase of C4 parks low at the boundary.
    start_note(1, 0);
    wait_spk(1'b1, n);
    repeat (50) @(negedge clk);
    key_on = 1'b0;
    wait_idle(1'b1, n, g);
    check_eq("c4_release_len",    n, exp_div(1, 0) - 50);
    check_eq("c4_release_glitch", g, 0);
    check_eq("c4_release_spk",    int'(speaker), 0);
    check_eq("c4_release_curkey", int'(cur_key), 0);

    // Rest key while gate held behaves as release.
    start_note(3, 0);
    wait_spk(1'b1, n);
    repeat (10) @(negedge clk);
    key = 4'd15;
    wait_idle(1'b1, n, g);
    check_eq("rest_release_len", n, exp_div(3, 0) - 10);
    check_eq("rest_release_glitch", g, 0);

    // Drop then reassert with G4 before the boundary: no idle visit.
    start_note(1, 0);
    wait_spk(1'b1, n);
    repeat (20) @(negedge clk);
    key_on = 1'b0;
    repeat (2) @(negedge clk);
    start_note(5, 0);
    n = 0; dropped = 0;
    while (speaker === 1'b1 && n < MAXW) begin
      @(negedge clk);
      n++;
      if (active !== 1'b1) dropped++;
    end
    check_eq("reassert_finish",  n, exp_div(1, 0) - 22);
    check_eq("reassert_dropped", dropped, 0);
    check_eq("reassert_cur_key", int'(cur_key), 5);
    wait_spk(1'b1, n); check_eq("reassert_g4_low", n, exp_div(5, 0));
    key_on = 1'b0;
    wait_idle(1'b1, n, g); check_eq("reassert_release", n, exp_div(5, 0));

    // Asynchronous reset mid-high, then restart.
    start_note(6, 0);
    wait_spk(1'b1, n);
    repeat (30) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check_eq("async_rst_speaker", int'(speaker), 0);
    check_eq("async_rst_active",  int'(active),  0);
    check_eq("async_rst_cur_key", int'(cur_key), 0);
    @(negedge clk);
    rst = 1'b0;
    wait_spk(1'b1, n); check_eq("post_rst_rise", n, 2);
    wait_spk(1'b0, n); check_eq("post_rst_high", n, exp_div(6, 0));
    key_on = 1'b0;
    wait_idle(1'b0, n, g); check_eq("post_rst_release", n, exp_div(6, 0));

    // Randomized: start, mid-phase pitch/octave change, release by gate or rest key.
    for (int t = 0; t < 12; t++) begin
      k1 = int'($urandom_range(1, 14)); o1 = int'($urandom_range(0, 3));
      k2 = int'($urandom_range(1, 14)); o2 = int'($urandom_range(0, 3));
      d1 = exp_div(k1, o1);
      d2 = exp_div(k2, o2);
      start_note(k1, o1);
      wait_spk(1'b1, n); check_eq("rnd_rise_latency", n, 2);
      check_eq("rnd_cur_key1", int'(cur_key), k1);
      off = int'($urandom_range(1, d1 - 3));
      repeat (off) @(negedge clk);
      key = 4'(k2); octave = 2'(o2);
      wait_spk(1'b0, n); check_eq("rnd_first_half", n, d1 - off);
      check_eq("rnd_cur_key2", int'(cur_key), k2);
      wait_spk(1'b1, n); check_eq("rnd_second_half", n, d2);
      off = int'($urandom_range(1, d2 - 3));
      repeat (off) @(negedge clk);
      if ($urandom_range(0, 1) == 0) key_on = 1'b0;
      else key = ($urandom_range(0, 1) == 0) ? 4'd0 : 4'd15;
      wait_idle(1'b1, n, g);
      check_eq("rnd_release_len",    n, d2 - off);
      check_eq("rnd_release_glitch", g, 0);
      check_eq("rnd_release_spk",    int'(speaker), 0);
      check_eq("rnd_release_curkey", int'(cur_key), 0);
      key_on = 1'b0;
      @(negedge clk);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/buzzer_tone_gen.md
Name: buzzer_tone_gen

Overview:
- Downstream stage of the song player: consumes the player's 4-bit key code and key_on gate and drives the piano buzzer pin with a square wave at the note's pitch.
- Note changes are glitch-free: a new pitch takes effect only at a half-period boundary.
- Release also waits for a half-period boundary, so the buzzer always parks low.
- Also exports status outputs (active flag, sounding key) for LEDs and the display.

Parameters:
- CLK_HZ, 100000000, system clock frequency in Hz; divider table computed from it at elaboration.
- DIV_W, 19, width of half-period counter/divider registers; must hold 2x the C4 divider.

Ports:
- clk  input  1  system clock
- rst  input  1  reset; asynchronous assert, active-high
- key  input  4  note code: 0 = rest, 1..7 = C4..B4, 8..14 = C5..B5, 15 = rest
- key_on  input  1  gate from the player; 1 = note should sound
- octave  input  2  0 = as coded, 1 = up one octave, 2 = down one octave, 3 = treated as 0
- speaker  output  1  square wave to buzzer
- active  output  1  high whenever state != IDLE
- cur_key  output  4  key code whose divider is currently sounding; 0 when IDLE

Behaviour:
- Input stage:
  - key, key_on and octave are registered once (key_r, on_r, oct_r); all decisions use the registered copies.
  - Input-to-effect latency is therefore 1 cycle of registering, plus FSM action on the following edge.
- Divider LUT (combinational):
  - div_lut(k) = round(CLK_HZ / (2*f_k)), with f for C4..B4 = 262, 294, 330, 349, 392, 440, 494 Hz.
  - Keys 8..14 use the base value >> 1 (integer truncation).
  - Octave adjust: octave 1 gives div >> 1; octave 2 gives div << 1.
  - Defaults: C4 = 190840, A4 = 113636, B4 = 101215.
- Sound condition: want = on_r & (key_r not in {0, 15}).
- Reset (async, any time, including mid-note):
  - speaker = 0, active = 0, cur_key = 0.
  - Counter = 0, div_cur = 0, state = IDLE.
- FSM states: IDLE, PLAY, RELEASE.
- IDLE:
  - speaker held 0, counter held 0.
  - If want: div_cur <= lut(key_r, oct_r), cur_key <= key_r, speaker <= 1, counter <= 0, go to PLAY.
  - So the first rising edge of speaker appears 2 clk after key/key_on change at the ports.
- PLAY:
  - counter increments each cycle.
  - At boundary (counter == div_cur - 1): counter <= 0, speaker toggles, and div_cur <= div_next, cur_key <= key_next.
  - div_next / key_next track lut(key_r, oct_r) / key_r every cycle; a pitch or octave change therefore applies at the next boundary only, with no partial periods.
  - If !want: go to RELEASE. The counter keeps running; the boundary rule is unchanged in that same cycle.
- RELEASE:
  - Continues counting with div_cur; div_next is frozen.
  - At the next boundary: speaker <= 0, counter <= 0, cur_key <= 0, go to IDLE.
  - If want reasserts before the boundary: return to PLAY, div_next reloaded from current inputs, no silence gap.
- Simultaneous boundary and key change in the same cycle: the boundary uses the div_next registered before that cycle; the new key applies at the following boundary.
- Half-period is exactly div_cur cycles, so period = 2*div_cur.
- Rests (key 0/15) while on_r = 1 behave as release.

Decomposition:
- Package piano_pkg holds:
  - key-code constants (KEY_REST = 0, KEY_REST_ALT = 15, KEY_C4 = 1 .. KEY_B5 = 14);
  - note frequency constants (262..494);
  - octave encodings;
  - FSM state typedef.
- Sub-module note_div_lut: purely combinational (key, octave) -> divider, parameterised by CLK_HZ and DIV_W, instantiated once.

Test Plan:
- key = 6, key_on = 1 from reset → speaker rises 2 clk later; high 113636 cycles, low 113636, repeating; active = 1, cur_key = 6.
- While A4 plays, change key to 7 mid-half-period → current half-period completes at 113636 cycles; next half-periods are 101215; no short pulse.
- key = 1 with octave = 2 → half-period 381680; octave = 1 → 95420; octave = 3 → 190840.
- Drop key_on mid high-phase of C4 → speaker stays high until that half-period ends, then 0; active falls the same edge; cur_key = 0.
- Drop key_on, then reassert key = 5 before the boundary → no IDLE visit, active stays 1; G4 (127551) applies from the boundary.
- Assert rst mid-high-phase → speaker, active, cur_key go 0 without waiting for clk. After release with key_on = 1, the start sequence repeats as in scenario 1.
